// File: rtl/exmem_arbiter.sv
// Two-master Wishbone-classic to fixed-latency memory arbiter.
// Round-robin issue, one request in flight per master, in-order tag FIFO routes responses back.
module exmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [3:0]    m0_sel,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_w,
  output logic          m0_ack,
  output logic [DW-1:0] m0_dat_r,

  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [3:0]    m1_sel,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_w,
  output logic          m1_ack,
  output logic [DW-1:0] m1_dat_r,

  output logic          mem_stb,
  output logic          mem_we,
  output logic [3:0]    mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_w,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_dat_r,

  output logic          err
);

  logic       pend0, pend1;
  logic       last_grant;   // 1 = m1 was granted most recently
  logic [1:0] fifo_id;
  logic [1:0] fifo_live;
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;

  logic       elig0, elig1, issue, grant;
  logic       pop, head_id, head_live;
  logic [1:0] slot_valid;

  always_comb begin
    elig0 = m0_cyc & m0_stb & ~pend0 & ~m0_ack;
    elig1 = m1_cyc & m1_stb & ~pend1 & ~m1_ack;
    issue = elig0 | elig1;
    grant = (elig0 && elig1) ? ~last_grant : elig1;

    pop     = mem_ack & (count != 2'd0);
    head_id = fifo_id[rd_ptr];
    // A master dropping cyc in the very cycle its response lands has also aborted.
    head_live = fifo_live[rd_ptr] & (head_id ? m1_cyc : m0_cyc);

    for (int i = 0; i < 2; i++) begin
      slot_valid[i] = (count == 2'd2) || (count == 2'd1 && rd_ptr == 1'(i));
    end
  end

  // NOTE: tag storage carries no reset; occupancy and pointers alone decide which slots are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (slot_valid[i] && !(fifo_id[i] ? m1_cyc : m0_cyc)) begin
        fifo_live[i] <= 1'b0;
      end
    end
    if (issue) begin
      fifo_id[wr_ptr]   <= grant;
      fifo_live[wr_ptr] <= 1'b1;
    end
  end

  // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_stb    <= 1'b0;
      mem_we     <= 1'b0;
      mem_sel    <= '0;
      mem_addr   <= '0;
      mem_dat_w  <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_dat_r   <= '0;
      m1_dat_r   <= '0;
      err        <= 1'b0;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
    end else begin
      mem_stb <= issue;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;

      if (issue) begin
        last_grant <= grant;
        wr_ptr     <= ~wr_ptr;
        mem_we     <= grant ? m1_we    : m0_we;
        mem_sel    <= grant ? m1_sel   : m0_sel;
        mem_addr   <= grant ? m1_adr   : m0_adr;
        mem_dat_w  <= grant ? m1_dat_w : m0_dat_w;
        if (grant) pend1 <= 1'b1;
        else       pend0 <= 1'b1;
      end

      // Issue and pop never touch the same pend flag: a pending master is never eligible.
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (head_id) begin
          pend1  <= 1'b0;
          m1_ack <= head_live;
          if (head_live) m1_dat_r <= mem_dat_r;
        end else begin
          pend0  <= 1'b0;
          m0_ack <= head_live;
          if (head_live) m0_dat_r <= mem_dat_r;
        end
      end else if (mem_ack) begin
        err <= 1'b1;
      end

      count <= count + {1'b0, issue} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_exmem_arbiter.sv
// Self-checking bench for exmem_arbiter: 11-cycle in-order byte-enabled memory model,
// directed scenarios plus randomized per-master traffic checked against shadow memories.
module tb_exmem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m0_ack;
  logic [3:0]    m0_sel;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_w, m0_dat_r;
  logic          m1_cyc, m1_stb, m1_we, m1_ack;
  logic [3:0]    m1_sel;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_w, m1_dat_r;
  logic          mem_stb, mem_we, mem_ack;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dat_w, mem_dat_r;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  int          iss_cyc[$];
  logic [31:0] iss_adr[$];
  bit          force_ack = 1'b0;

  exmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_ack(m0_ack), .m0_dat_r(m0_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_ack(m1_ack), .m1_dat_r(m1_dat_r),
    .mem_stb(mem_stb), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_dat_w(mem_dat_w), .mem_ack(mem_ack), .mem_dat_r(mem_dat_r),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m0_ack === 1'b1) ack_cnt0 <= ack_cnt0 + 1;
    if (m1_ack === 1'b1) ack_cnt1 <= ack_cnt1 + 1;
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  // Memory model: requests seen in cycle c are answered in cycle c+LAT, in order.
  initial begin
    rsp_t rsp;
    mem_ack   = 1'b0;
    mem_dat_r = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      while (rsp_q.size() != 0 && rsp_q[0].due < cyc) void'(rsp_q.pop_front());
      if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
        mem_ack   = 1'b1;
        mem_dat_r = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else if (force_ack) begin
        mem_ack   = 1'b1;
        mem_dat_r = $urandom;
      end
      if (mem_stb === 1'b1) begin
        iss_cyc.push_back(cyc);
        iss_adr.push_back(mem_addr);
        if (mem_we) begin
          mem_arr[mem_addr] = merge(rd_mem(mem_addr), mem_dat_w, mem_sel);
          rsp.data = $urandom;
        end else begin
          rsp.data = rd_mem(mem_addr);
        end
        rsp.due = cyc + LAT;
        rsp_q.push_back(rsp);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic on, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = on; m0_stb = on; m0_we = we; m0_sel = sel; m0_adr = adr; m0_dat_w = dat;
    end else begin
      m1_cyc = on; m1_stb = on; m1_we = we; m1_sel = sel; m1_adr = adr; m1_dat_w = dat;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_ack : m1_ack;
  endfunction

  function automatic logic [31:0] dat_of(input int m);
    return (m == 0) ? m0_dat_r : m1_dat_r;
  endfunction

  // Full transaction: stb is held through the ack cycle and dropped one cycle later.
  task automatic txn(input int m, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, output logic [31:0] rdata, output int lat);
    int start;
    int n;
    start = cyc;
    n = 0;
    drive(m, 1'b1, we, sel, adr, dat);
    do begin
      @(negedge clk);
      n++;
    end while (ack_of(m) !== 1'b1 && n < 60);
    chk($sformatf("ack_m%0d", m), ack_of(m), 1'b1);
    lat   = cyc - start;
    rdata = dat_of(m);
    @(negedge clk);
    drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_master(input int m);
    logic [31:0] shadow [8];
    logic [31:0] base_a, a, d, rdata;
    logic [3:0]  sel;
    logic        we;
    int          idx, lat;
    base_a = (m == 0) ? 32'h400 : 32'h800;
    for (int i = 0; i < 8; i++) shadow[i] = 32'h0;
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      idx = int'($urandom_range(0, 7));
      a   = base_a + 32'(idx * 4);
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      d   = $urandom;
      txn(m, we, a, sel, d, rdata, lat);
      chk($sformatf("rand_lat_m%0d", m), (lat == 13 || lat == 14), 1'b1);
      if (we) shadow[idx] = merge(shadow[idx], d, sel);
      else    chk($sformatf("rand_rd_m%0d_a%0h", m, a), rdata, shadow[idx]);
    end
  endtask

  initial begin
    logic [31:0] rd0, rd1;
    int          lat0, lat1, base, n, a0, a1, diff;
    logic        alt_ok;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mem_arr[32'h10] = 32'hCAFEF00D;
    mem_arr[32'h30] = 32'h12345678;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_stb", mem_stb, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_dat_r", {m0_dat_r, m1_dat_r}, 64'h0);
    chk("rst_err", err, 1'b0);
    repeat (12) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_stb", mem_stb, 1'b0);

    // Single read with stb held through the ack cycle
    iss_cyc.delete(); iss_adr.delete();
    base = cyc;
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, rd0, lat0);
    repeat (3) @(negedge clk);
    chk("t1_issue_count", iss_cyc.size(), 1);
    chk("t1_issue_cycle", iss_cyc[0] - base, 1);
    chk("t1_latency", lat0, 13);
    chk("t1_data", rd0, 32'hCAFEF00D);
    chk("t1_dat_r_hold", m0_dat_r, 32'hCAFEF00D);

    // Tie straight after reset: m0 wins
    reset_dut();
    iss_cyc.delete(); iss_adr.delete();
    base = cyc;
    fork
      txn(0, 1'b0, 32'h10, 4'hF, 32'h0, rd0, lat0);
      txn(1, 1'b0, 32'h30, 4'hF, 32'h0, rd1, lat1);
    join
    chk("t2_first_adr", iss_adr[0], 32'h10);
    chk("t2_first_cycle", iss_cyc[0] - base, 1);
    chk("t2_second_adr", iss_adr[1], 32'h30);
    chk("t2_second_cycle", iss_cyc[1] - base, 2);
    chk("t2_lat_m0", lat0, 13);
    chk("t2_lat_m1", lat1, 14);
    chk("t2_data_m0", rd0, 32'hCAFEF00D);
    chk("t2_data_m1", rd1, 32'h12345678);

    // Byte-enabled write then read-back
    txn(1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd1, lat1);
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0, rd1, lat1);
    chk("t3_byte_rd", rd1, 32'h00BB00DD);

    // Abort: m1 drops cyc 3 cycles after request, then re-requests
    iss_cyc.delete(); iss_adr.delete();
    base = cyc;
    drive(1, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
    repeat (3) @(negedge clk);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    drive(1, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
    n = 0;
    while (m1_ack !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ack_seen", m1_ack, 1'b1);
    chk("t4_ack_cycle", cyc - base, 26);
    chk("t4_issue_count", iss_cyc.size(), 2);
    chk("t4_reissue_cycle", iss_cyc[1] - base, 14);
    chk("t4_data", m1_dat_r, 32'h12345678);
    chk("t4_err", err, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Spurious ack with nothing in flight
    repeat (2) @(negedge clk);
    chk("t5_err_before", err, 1'b0);
    a0 = ack_cnt0;
    a1 = ack_cnt1;
    @(posedge clk);
    force_ack = 1'b1;
    @(posedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("t5_err_set", err, 1'b1);
    repeat (10) @(negedge clk);
    chk("t5_err_sticky", err, 1'b1);
    chk("t5_no_master_ack", (ack_cnt0 - a0) + (ack_cnt1 - a1), 0);
    reset_dut();
    chk("t5_err_cleared", err, 1'b0);

    // Back-to-back fairness over 40 cycles
    iss_cyc.delete(); iss_adr.delete();
    a0 = ack_cnt0;
    a1 = ack_cnt1;
    base = cyc;
    fork
      begin
        int k;
        logic [31:0] r;
        int l;
        k = 0;
        while (cyc < base + 40) begin
          txn(0, 1'b0, 32'h100 + 32'(4 * k), 4'hF, 32'h0, r, l);
          k++;
        end
      end
      begin
        int k;
        logic [31:0] r;
        int l;
        k = 0;
        while (cyc < base + 40) begin
          txn(1, 1'b0, 32'h200 + 32'(4 * k), 4'hF, 32'h0, r, l);
          k++;
        end
      end
    join
    repeat (2) @(negedge clk);
    alt_ok = (iss_adr.size() >= 4) && (iss_adr[0][9:8] == 2'b01);
    for (int i = 1; i < iss_adr.size(); i++) begin
      if (iss_adr[i][9:8] == iss_adr[i-1][9:8]) alt_ok = 1'b0;
    end
    chk("t6_alternate", alt_ok, 1'b1);
    diff = (ack_cnt0 - a0) - (ack_cnt1 - a1);
    chk("t6_balance", (diff >= -1 && diff <= 1), 1'b1);
    chk("t6_progress", ((ack_cnt0 - a0) >= 2 && (ack_cnt1 - a1) >= 2), 1'b1);

    // Randomized concurrent traffic against per-master shadow memories
    fork
      rand_master(0);
      rand_master(1);
    join
    repeat (3) @(negedge clk);
    chk("final_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
